dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 64-word data memory between the CPU load/store path and an auxiliary master, such as a program loader or debug port. Sits between the core's data interface and dmem, and drives dmem's `we`, `a` and `wd` while returning its `rd`. The CPU has priority, but the auxiliary master is protected from starvation by a bounded wait. The auxiliary master may lock the memory for short bursts. Grants are decided combinationally, and transfers complete in the granted cycle.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive denied aux cycles before the aux master is forced a grant (1..15).
- `MAX_LOCK`, default 8: maximum consecutive locked aux grants before one cycle is yielded to the CPU (1..15).

Ports:
- `clk`  in  1  the single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`, `cpu_we`  in  1  CPU access request / write enable.
- `cpu_a`, `cpu_wd`  in  32  CPU byte address / write data.
- `cpu_rd`  out  32  CPU read data; valid when `cpu_gnt` is high.
- `cpu_gnt`  out  1  CPU access performed this cycle.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_gnt`; the core holds its PC and registers.
- `aux_req`, `aux_we`, `aux_lock`  in  1  aux request / write enable / burst lock.
- `aux_a`, `aux_wd`  in  32  aux byte address / write data.
- `aux_rd`  out  32  aux read data; valid when `aux_gnt` is high.
- `aux_gnt`  out  1  aux access performed this cycle.
- `mem_we`  out  1  to dmem `we`.
- `mem_a`, `mem_wd`  out  32  to dmem `a` / `wd`.
- `mem_rd`  in  32  from dmem `rd`, which is a combinational read.
- `err_oob`  out  1  sticky flag: a granted access had `a[31:8]` nonzero.

## Operation
FSM states are `S_CPU` (reset state) and `S_AUX_LOCK`. There are two 4-bit counters: `wait_cnt` and `lock_cnt`.

In `S_CPU`:
- Grant the aux master if `aux_req & (~cpu_req | wait_cnt == MAX_WAIT)`; otherwise grant the CPU if `cpu_req`.
- Go to `S_AUX_LOCK` when the aux master is granted with `aux_lock` high. `lock_cnt` becomes 1.

In `S_AUX_LOCK`:
- Grant the aux master while `aux_req & aux_lock`; `lock_cnt` increments on each grant.
- Leave to `S_CPU` when `aux_req` or `aux_lock` drops. The CPU is serviced in that same cycle if it is requesting.
- Also leave to `S_CPU` when `lock_cnt == MAX_LOCK` and `cpu_req` is high. That cycle grants the CPU and clears `lock_cnt`.
- If `lock_cnt == MAX_LOCK` and the CPU is idle, the aux grant continues and `lock_cnt` saturates.

`wait_cnt` rules:
- Increments on each cycle with `aux_req & ~aux_gnt`.
- Clears on `aux_gnt` or `~aux_req`.
- Saturates at `MAX_WAIT`.

Datapath:
- At most one grant per cycle.
- The memory bus is muxed from the granted master.
- With no grant, `mem_we=0`, and `mem_a`/`mem_wd` hold the CPU values.
- `cpu_rd` and `aux_rd` equal `mem_rd` when the respective master is granted, else 0.

Out-of-range accesses (`a[31:8] != 0`):
- The access is still granted.
- `mem_we` is forced to 0 and the read data returns 0.
- `err_oob` is set on the next posedge and clears only on reset.

Reset behaviour:
- On reset: state `S_CPU`, both counters 0, `err_oob` 0.
- All grant outputs are 0 while `rst_n` is low.
- `mem_we` is 0 during reset.
- Reset asserted mid-lock aborts the lock immediately.

## Timing
- Grant, stall and read data are combinational from the requests and the registered state. Zero-cycle latency.
- A write commits at the posedge ending the granted cycle.
- Forced aux grant: with both masters requesting continuously, the aux master is granted on its (MAX_WAIT+1)th request cycle. CPU stall for that event is 1 cycle.
- Locked burst: with the CPU requesting continuously, at most MAX_LOCK consecutive aux grants, then exactly 1 CPU cycle.
- Requests must hold their address and data stable until granted.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds two 16-bit saturating counters, reset to 0.
  - `stat_conflict`: cycles with both requests high.
  - `stat_force`: forced aux grants.
  - Both are exposed as output ports `stat_conflict` and `stat_force`.
- Not defined: the counters and the ports are absent, and arbitration behaviour is identical.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `arb_state_t` (`S_CPU`, `S_AUX_LOCK`);
  - the constants `DMEM_IDX_HI=7`, `DMEM_IDX_LO=2`;
  - the out-of-range mask for `a[31:8]`.
- Single module; no sub-module is needed. The optional stats counters stay inline, in a guarded block.

## Test plan
- CPU-only write then read: write 0xDEADBEEF to 0x10, then read 0x10 → `cpu_gnt=1` both cycles, `cpu_rd=0xDEADBEEF`, `cpu_stall=0`.
- Both masters request continuously, `MAX_WAIT=4` → aux is granted on its 5th cycle, `cpu_stall` pulses high for 1 cycle, `wait_cnt` returns to 0.
- Aux locked burst of 12 writes to 0x00..0x2C, CPU requesting, `MAX_LOCK=8` → 8 aux grants, 1 CPU grant, then the remaining aux transfers are sequenced under normal arbitration. All 12 words read back correctly.
- Aux writes to 0x100 → `aux_gnt=1`, `mem_we=0`, `err_oob=1` from the next cycle, and word 0 is unchanged.
- `rst_n` driven low mid-lock → all grants 0 immediately. After release: state `S_CPU`, a CPU request is granted at once, and `err_oob=0`.
- With `DMEM_ARB_STATS_EN`: 10 conflict cycles, including 2 forced grants → `stat_conflict=10`, `stat_force=2`.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU      = 1'b0,
    S_AUX_LOCK = 1'b1
  } arb_state_t;

  // Word index bits of a byte address into the 64-word dmem.
  localparam int unsigned DMEM_IDX_HI = 7;
  localparam int unsigned DMEM_IDX_LO = 2;

  // Any address bit set under this mask lies outside the 256-byte dmem.
  localparam logic [31:0] DMEM_OOB_MASK = 32'hFFFF_FF00;

  function automatic logic is_oob(input logic [31:0] addr);
    return |(addr & DMEM_OOB_MASK);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port dmem between the CPU and an auxiliary
// master. The CPU has priority, the aux master gets a forced grant after a
// bounded wait and may lock the memory for bursts of limited length.
// Optional build macro: DMEM_ARB_STATS_EN adds conflict/forced-grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic        aux_lock,
  input  logic [31:0] aux_a,
  input  logic [31:0] aux_wd,
  output logic [31:0] aux_rd,
  output logic        aux_gnt,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        err_oob
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_conflict,
  output logic [15:0] stat_force
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  arb_state_t state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       err_oob_q, err_oob_d;
  logic       oob_acc;
  logic       we_sel;

  // Grant decision and FSM next state, from requests and registered state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cpu_gnt    = 1'b0;
    aux_gnt    = 1'b0;
    // NOTE: grants are gated by rst_n directly so they drop the moment reset
    // asserts, without waiting for the state register to clear.
    if (rst_n) begin
      case (state_q)
        S_CPU: begin
          if (aux_req && (!cpu_req || wait_cnt_q == MAX_WAIT_C)) begin
            aux_gnt = 1'b1;
            if (aux_lock) begin
              state_d    = S_AUX_LOCK;
              lock_cnt_d = 4'd1;
            end
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        S_AUX_LOCK: begin
          if (aux_req && aux_lock) begin
            if (lock_cnt_q == MAX_LOCK_C && cpu_req) begin
              // Burst limit reached: yield one cycle to the waiting CPU.
              cpu_gnt    = 1'b1;
              state_d    = S_CPU;
              lock_cnt_d = 4'd0;
            end else begin
              aux_gnt = 1'b1;
              if (lock_cnt_q != MAX_LOCK_C) lock_cnt_d = lock_cnt_q + 4'd1;
            end
          end else begin
            state_d    = S_CPU;
            lock_cnt_d = 4'd0;
            cpu_gnt    = cpu_req;
          end
        end
        default: begin
          state_d    = S_CPU;
          lock_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Starvation counter: counts denied aux cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!aux_req || aux_gnt)         wait_cnt_d = 4'd0;
    else if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // Memory bus mux, out-of-range suppression and read data return.
  always_comb begin
    mem_a     = aux_gnt ? aux_a  : cpu_a;
    mem_wd    = aux_gnt ? aux_wd : cpu_wd;
    we_sel    = aux_gnt ? aux_we : (cpu_gnt & cpu_we);
    oob_acc   = (cpu_gnt | aux_gnt) & is_oob(mem_a);
    mem_we    = we_sel & ~oob_acc;
    cpu_rd    = (cpu_gnt && !oob_acc) ? mem_rd : 32'd0;
    aux_rd    = (aux_gnt && !oob_acc) ? mem_rd : 32'd0;
    cpu_stall = cpu_req & ~cpu_gnt;
    err_oob_d = err_oob_q | oob_acc;
  end

  assign err_oob = err_oob_q;

  // State, counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CPU;
      wait_cnt_q <= 4'd0;
      lock_cnt_q <= 4'd0;
      err_oob_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      err_oob_q  <= err_oob_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflict_q;
  logic [15:0] stat_force_q;
  logic        forced_gnt;

  // An aux grant out of S_CPU while the CPU requests can only be a forced one.
  assign forced_gnt = (state_q == S_CPU) & aux_gnt & cpu_req;

  // Saturating conflict and forced-grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict_q <= 16'd0;
      stat_force_q    <= 16'd0;
    end else begin
      if (cpu_req && aux_req && stat_conflict_q != 16'hFFFF)
        stat_conflict_q <= stat_conflict_q + 16'd1;
      if (forced_gnt && stat_force_q != 16'hFFFF)
        stat_force_q <= stat_force_q + 16'd1;
    end
  end

  assign stat_conflict = stat_conflict_q;
  assign stat_force    = stat_force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 64-word dmem model.
// Build with DMEM_ARB_STATS_EN defined to also cover the stats counters.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_a, cpu_wd, cpu_rd;
  logic        cpu_gnt, cpu_stall;
  logic        aux_req, aux_we, aux_lock;
  logic [31:0] aux_a, aux_wd, aux_rd;
  logic        aux_gnt;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        err_oob;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflict, stat_force;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock),
    .aux_a(aux_a), .aux_wd(aux_wd), .aux_rd(aux_rd), .aux_gnt(aux_gnt),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err_oob(err_oob)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflict(stat_conflict), .stat_force(stat_force)
`endif
  );

  // Single-port dmem: combinational read, write at posedge.
  logic [31:0] dmem [64];
  assign mem_rd = dmem[mem_a[DMEM_IDX_HI:DMEM_IDX_LO]];
  always_ff @(posedge clk) begin
    if (mem_we) dmem[mem_a[DMEM_IDX_HI:DMEM_IDX_LO]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_a = 0; cpu_wd = 0;
    aux_req = 0; aux_we = 0; aux_lock = 0; aux_a = 0; aux_wd = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit g_aux [64];
  bit g_cpu [64];

  initial begin
    int idx, cyc, first_aux, run;
    idle();
    rst_n = 1'b0;
    cpu_req = 1; aux_req = 1;
    step(); step();
    // Reset: no grants, no write, no error even with both masters requesting.
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_aux_gnt", 32'(aux_gnt), 32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_err_oob", 32'(err_oob), 32'd0);
    idle();
    @(negedge clk) rst_n = 1'b1;
    step();

    // CPU-only write then read of 0x10.
    cpu_req = 1; cpu_we = 1; cpu_a = 32'h10; cpu_wd = 32'hDEADBEEF;
    #1;
    check("wr_cpu_gnt",   32'(cpu_gnt),   32'd1);
    check("wr_cpu_stall", 32'(cpu_stall), 32'd0);
    check("wr_mem_we",    32'(mem_we),    32'd1);
    step();
    cpu_we = 0;
    #1;
    check("rd_cpu_gnt",   32'(cpu_gnt),   32'd1);
    check("rd_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rd_cpu_rd",    cpu_rd,         32'hDEADBEEF);
    step();

    // Both request continuously: aux forced on its 5th request cycle.
    aux_req = 1; aux_a = 32'h10;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("force_aux_gnt_c%0d", c), 32'(aux_gnt),   (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("force_stall_c%0d", c),   32'(cpu_stall), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) check("force_aux_rd", aux_rd, 32'hDEADBEEF);
      if (c == 6) check("force_wait_clr", 32'(dut.wait_cnt_q), 32'd0);
      step();
    end
    idle();
    step();

    // Locked aux burst of 12 writes with the CPU reading 0x3C throughout.
    cpu_req = 1; cpu_a = 32'h3C;
    aux_req = 1; aux_lock = 1; aux_we = 1;
    idx = 0; cyc = 0;
    while (idx < 12 && cyc < 60) begin
      aux_a  = 32'(idx * 4);
      aux_wd = 32'hA500_0000 + 32'(idx);
      #1;
      g_aux[cyc] = aux_gnt;
      g_cpu[cyc] = cpu_gnt;
      if (aux_gnt && cpu_gnt) check("burst_dual_gnt", 32'd1, 32'd0);
      if (aux_gnt) idx++;
      cyc++;
      step();
    end
    check("burst_done", 32'(idx), 32'd12);
    idle();
    first_aux = -1;
    for (int i = 0; i < cyc; i++) if (first_aux < 0 && g_aux[i]) first_aux = i;
    run = 0;
    if (first_aux >= 0)
      for (int i = first_aux; i < cyc && g_aux[i]; i++) run++;
    check("burst_first_aux", 32'(first_aux), 32'd4);
    check("burst_run_len",   32'(run),       32'd8);
    check("burst_cpu_yield", 32'(g_cpu[12]), 32'd1);
    step();
    for (int i = 0; i < 12; i++) begin
      cpu_req = 1; cpu_a = 32'(i * 4);
      #1;
      check($sformatf("burst_rb_%0d", i), cpu_rd, 32'hA500_0000 + 32'(i));
      step();
    end
    idle();

    // Out-of-range aux write to 0x100.
    aux_req = 1; aux_we = 1; aux_a = 32'h100; aux_wd = 32'h1234_5678;
    #1;
    check("oob_aux_gnt", 32'(aux_gnt), 32'd1);
    check("oob_mem_we",  32'(mem_we),  32'd0);
    check("oob_err_pre", 32'(err_oob), 32'd0);
    step();
    idle();
    cpu_req = 1; cpu_a = 32'h0;
    #1;
    check("oob_err_post", 32'(err_oob), 32'd1);
    check("oob_word0",    cpu_rd,        32'hA500_0000);
    step();
    idle();

    // Reset asserted in the middle of a locked burst.
    aux_req = 1; aux_lock = 1; aux_a = 32'h20;
    step(); step();
    check("lock_state", 32'(dut.state_q), 32'(S_AUX_LOCK));
    cpu_req = 1; cpu_a = 32'h4;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_aux_gnt", 32'(aux_gnt), 32'd0);
    check("midrst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("midrst_mem_we",  32'(mem_we),  32'd0);
    check("midrst_err_oob", 32'(err_oob), 32'd0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check("postrst_state",   32'(dut.state_q), 32'(S_CPU));
    check("postrst_cpu_gnt", 32'(cpu_gnt),     32'd1);
    check("postrst_aux_gnt", 32'(aux_gnt),     32'd0);
    check("postrst_cpu_rd",  cpu_rd,           32'hA500_0001);
    check("postrst_err_oob", 32'(err_oob),     32'd0);
    idle();
    step();

`ifdef DMEM_ARB_STATS_EN
    // Ten conflict cycles from a fresh reset: forced grants on cycles 5 and 10.
    rst_n = 1'b0;
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check("stat_rst_conflict", 32'(stat_conflict), 32'd0);
    cpu_req = 1; aux_req = 1;
    repeat (10) step();
    idle();
    step();
    check("stat_conflict", 32'(stat_conflict), 32'd10);
    check("stat_force",    32'(stat_force),    32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
